// File: rtl/interpolator_intensity.sv
// Per-transducer intensity interpolator: each frame steps every transducer's applied
// intensity toward its target by at most its update rate, clamping at the target.
module interpolator_intensity #(
  parameter int DEPTH = 249
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN_VALID,
  input  logic [7:0] INTENSITY_TARGET,
  input  logic [7:0] UPDATE_RATE,
  output logic [7:0] INTENSITY_OUT,
  output logic       DOUT_VALID,
  output logic       BUSY
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            w_last;
  logic            w_accept;

  // stage 1: registered request plus the RAM read data
  logic            r_v1;
  logic [7:0]      r_tgt;
  logic [7:0]      r_rate;
  logic [IW-1:0]   r_widx;
  logic [7:0]      r_cur;

  logic signed [8:0] w_diff;
  logic [8:0]        w_mag;
  logic [7:0]        w_next;

  logic [7:0]      r_mem [DEPTH];
  logic            w_we;
  logic [IW-1:0]   w_waddr;
  logic [7:0]      w_wdata;

  logic [7:0]      r_out;
  logic            r_dout_valid;

  assign w_last   = (r_idx == IW'(DEPTH - 1));
  assign w_accept = DIN_VALID && (r_state == RUN);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      CLEAR: begin
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = RUN;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      RUN: begin
        if (DIN_VALID) w_idx_nxt = w_last ? '0 : r_idx + 1'b1;
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= CLEAR;
      r_idx        <= '0;
      r_v1         <= 1'b0;
      r_tgt        <= '0;
      r_rate       <= '0;
      r_widx       <= '0;
      r_out        <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_v1         <= w_accept;
      if (w_accept) begin
        r_tgt  <= INTENSITY_TARGET;
        r_rate <= UPDATE_RATE;
        r_widx <= r_idx;
      end
      r_dout_valid <= r_v1;
      if (r_v1) r_out <= w_next;
    end
  end

  // Step never overshoots the target, so cur +/- rate stays inside [0,255].
  always_comb begin
    w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_cur});
    w_mag  = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
    w_next = r_cur;
    if (w_mag <= {1'b0, r_rate}) w_next = r_tgt;
    else if (!w_diff[8])         w_next = r_cur + r_rate;
    else                         w_next = r_cur - r_rate;
  end

  assign w_we    = (r_state == CLEAR) || r_v1;
  assign w_waddr = (r_state == CLEAR) ? r_idx : r_widx;
  assign w_wdata = (r_state == CLEAR) ? 8'd0 : w_next;

  // NOTE: the RAM has no reset; the CLEAR sweep zeroes it instead so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_cur <= r_mem[r_idx];
  end

  assign INTENSITY_OUT = r_out;
  assign DOUT_VALID    = r_dout_valid;
  assign BUSY          = (r_state == CLEAR);

endmodule

// File: tb/tb_interpolator_intensity.sv
// Directed bench for interpolator_intensity (DEPTH=4) with a timestamped scoreboard
// checking output values and the exact 2-cycle DIN_VALID -> DOUT_VALID latency.
module tb_interpolator_intensity;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic [7:0] INTENSITY_TARGET = '0;
  logic [7:0] UPDATE_RATE = '0;
  logic [7:0] INTENSITY_OUT;
  logic       DOUT_VALID;
  logic       BUSY;

  interpolator_intensity #(.DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .DIN_VALID        (DIN_VALID),
    .INTENSITY_TARGET (INTENSITY_TARGET),
    .UPDATE_RATE      (UPDATE_RATE),
    .INTENSITY_OUT    (INTENSITY_OUT),
    .DOUT_VALID       (DOUT_VALID),
    .BUSY             (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[DEPTH];
  int         m_idx;
  bit         run_mode;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] rate);
    int c = cur;
    int t = tgt;
    int r = rate;
    if (t > c) return (c + r > t) ? tgt : 8'(c + r);
    else       return (c - r < t) ? tgt : 8'(c - r);
  endfunction

  // Output monitor: DOUT_VALID must match the scoreboard timestamp every cycle.
  exp_t mon_e;
  bit   mon_exp_valid;
  always @(negedge CLK) begin
    if (RST_N) begin
      mon_exp_valid = (sb.size() > 0) && (sb[0].due == cyc);
      check("dout_valid", {31'd0, DOUT_VALID}, {31'd0, mon_exp_valid});
      if (mon_exp_valid) begin
        mon_e = sb.pop_front();
        if (DOUT_VALID) check("intensity_out", {24'd0, INTENSITY_OUT}, {24'd0, mon_e.val});
      end
      while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    end
  end

  task automatic step(input bit v, input logic [7:0] t, input logic [7:0] r);
    exp_t x;
    @(negedge CLK);
    DIN_VALID        = v;
    INTENSITY_TARGET = t;
    UPDATE_RATE      = r;
    if (v && run_mode) begin
      x.val = model_next(model[m_idx], t, r);
      x.due = cyc + 2;
      model[m_idx] = x.val;
      sb.push_back(x);
      m_idx = (m_idx + 1) % DEPTH;
    end
  endtask

  task automatic frame4(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                        input logic [7:0] t3, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3);
    step(1'b1, t0, r0);
    step(1'b1, t1, r1);
    step(1'b1, t2, r2);
    step(1'b1, t3, r3);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 8'd0, 8'd0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  // Called at the negedge where RST_N was just released; DIN_VALID pulses must be dropped.
  task automatic clear_phase();
    run_mode = 1'b0;
    DIN_VALID = 1'b1;
    INTENSITY_TARGET = 8'd77;
    UPDATE_RATE = 8'd9;
    check("busy_at_release", {31'd0, BUSY}, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      step(k < DEPTH, 8'd77, 8'd9);
      check("busy_clear", {31'd0, BUSY}, {31'd0, (k < DEPTH)});
    end
    run_mode = 1'b1;
  endtask

  task automatic reset_model();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'd0;
    m_idx    = 0;
    run_mode = 1'b0;
  endtask

  initial begin
    reset_model();
    repeat (3) @(negedge CLK);
    check("rst_dout_valid", {31'd0, DOUT_VALID}, 0);
    check("rst_intensity", {24'd0, INTENSITY_OUT}, 0);
    check("rst_busy", {31'd0, BUSY}, 1);
    RST_N = 1'b1;
    clear_phase();

    // ramp 0 -> 100 at 30 per frame
    repeat (4) frame4(8'd100, 8'd100, 8'd100, 8'd100, 8'd30, 8'd30, 8'd30, 8'd30);
    drain();

    // all to 200, then mixed directions, near-target, saturating target, zero rate
    frame4(8'd200, 8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255, 8'd255);
    repeat (2) frame4(8'd0, 8'd199, 8'd255, 8'd200, 8'd50, 8'd5, 8'd10, 8'd0);
    drain();

    // zero rate holds, full rate jumps
    frame4(8'd40, 8'd40, 8'd40, 8'd40, 8'd255, 8'd255, 8'd255, 8'd255);
    repeat (3) frame4(8'd80, 8'd80, 8'd80, 8'd80, 8'd0, 8'd0, 8'd0, 8'd0);
    frame4(8'd80, 8'd80, 8'd80, 8'd80, 8'd255, 8'd255, 8'd255, 8'd255);
    drain();

    // gapped frame, then a dense frame that must restart at idx 0
    step(1'b1, 8'd10, 8'd255);
    step(1'b0, 8'd99, 8'd255);
    step(1'b0, 8'd99, 8'd255);
    step(1'b1, 8'd20, 8'd255);
    step(1'b1, 8'd30, 8'd255);
    step(1'b0, 8'd99, 8'd255);
    step(1'b1, 8'd40, 8'd255);
    frame4(8'd11, 8'd22, 8'd33, 8'd44, 8'd255, 8'd255, 8'd255, 8'd255);
    drain();

    // reset mid-frame after idx 2
    step(1'b1, 8'd99, 8'd255);
    step(1'b1, 8'd99, 8'd255);
    step(1'b1, 8'd99, 8'd255);
    @(posedge CLK);
    #1;
    check("dout_valid_before_reset", {31'd0, DOUT_VALID}, 1);
    RST_N = 1'b0;
    DIN_VALID = 1'b0;
    reset_model();
    #1;
    check("midrst_dout_valid", {31'd0, DOUT_VALID}, 0);
    check("midrst_intensity", {24'd0, INTENSITY_OUT}, 0);
    check("midrst_busy", {31'd0, BUSY}, 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    clear_phase();
    frame4(8'd50, 8'd50, 8'd50, 8'd50, 8'd20, 8'd20, 8'd20, 8'd20);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
